// File: rtl/ifq.sv
// Instruction fetch queue: circular FIFO of {pc, instr} beats between fetch and decode.
// Back-pressures fetch with o_hold when full. A redirect flush drops every buffered entry.
module ifq #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PC_W    = 64,
   parameter int unsigned INSTR_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INSTR_W-1:0]     i_instr,
   input  logic [PC_W-1:0]        i_pc,
   input  logic                   i_instr_valid,
   output logic                   o_hold,
   input  logic                   i_flush,
   output logic [INSTR_W-1:0]     o_instr,
   output logic [PC_W-1:0]        o_pc,
   output logic                   o_valid,
   input  logic                   i_id_ready,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             hold_q, hold_d;
   logic             push;
   logic             pop;

   // Pointer and occupancy update. A flush beats push, pop and full.
   always_comb begin
      push     = i_instr_valid & ~hold_q & ~i_flush;
      pop      = valid_q & i_id_ready & ~i_flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
      // Status flags are precomputed from the next occupancy, so they depend on state only.
      valid_d = (cnt_d != '0);
      hold_d  = (cnt_d == CNT_W'(DEPTH));
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = {i_pc, i_instr};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         hold_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         hold_q   <= hold_d;
      end
   end

   // Entry storage needs no reset: the contents are only read while valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign o_valid = valid_q;
   assign o_hold  = hold_q;
   assign o_count = cnt_q;
   assign o_pc    = mem_q[rd_ptr_q].pc;
   assign o_instr = mem_q[rd_ptr_q].instr;

endmodule

// File: tb/tb_ifq.sv
// Bench for ifq: directed scenarios followed by random traffic.
// A queue-based reference model is checked by a monitor on the falling edge.
module tb_ifq;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_instr = '0;
   logic [63:0] i_pc = '0;
   logic        i_instr_valid = 1'b0;
   logic        o_hold;
   logic        i_flush = 1'b0;
   logic [31:0] o_instr;
   logic [63:0] o_pc;
   logic        o_valid;
   logic        i_id_ready = 1'b0;
   logic [2:0]  o_count;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t exp_q[$];
   bit   mon_en = 0;

   ifq #(.DEPTH(DEPTH), .PC_W(64), .INSTR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_instr      (i_instr),
      .i_pc         (i_pc),
      .i_instr_valid(i_instr_valid),
      .o_hold       (o_hold),
      .i_flush      (i_flush),
      .o_instr      (o_instr),
      .o_pc         (o_pc),
      .o_valid      (o_valid),
      .i_id_ready   (i_id_ready),
      .o_count      (o_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, expv);
      end
   endtask

   // Reference model: a FIFO that stores accepted beats and hands them out in order.
   always @(posedge clk) begin
      int  sz;
      bit  full_m, do_pop, do_push;
      ent_t e;
      if (!rst_n) begin
         exp_q.delete();
         mon_en = 1;
      end else if (i_flush) begin
         exp_q.delete();
      end else begin
         sz      = exp_q.size();
         full_m  = (sz == DEPTH);
         do_pop  = (sz != 0) && i_id_ready;
         do_push = i_instr_valid && !full_m;
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            e.pc    = i_pc;
            e.instr = i_instr;
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: compares status and the presented head with the model.
   always @(negedge clk) begin
      int sz;
      if (mon_en) begin
         sz = exp_q.size();
         chk("valid", 64'(o_valid), 64'(sz != 0));
         chk("hold", 64'(o_hold), 64'(sz == DEPTH));
         chk("count", 64'(o_count), 64'(sz));
         if (sz != 0) begin
            chk("head_pc", o_pc, exp_q[0].pc);
            chk("head_instr", 64'(o_instr), 64'(exp_q[0].instr));
         end
      end
   end

   // Apply one cycle of inputs, then return just after the rising edge.
   task automatic step(input logic v, input logic [63:0] pc, input logic rdy,
                       input logic fl, input logic rn);
      i_instr_valid = v;
      i_pc          = pc;
      i_instr       = $urandom;
      i_id_ready    = rdy;
      i_flush       = fl;
      rst_n         = rn;
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] BASE = 64'h8000_0000;

   initial begin
      logic [63:0] rpc;
      // Reset, then idle.
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_hold", 64'(o_hold), 64'd0);
      chk("rst_count", 64'(o_count), 64'd0);
      repeat (3) step(0, '0, 1, 0, 1);

      // Pass-through with decode always ready.
      for (int i = 0; i < 3; i++) step(1, BASE + 64'(4 * i), 1, 0, 1);
      step(0, '0, 1, 0, 1);

      // Fill, drop an extra beat while full, then drain.
      for (int i = 0; i < 4; i++) step(1, BASE + 64'(4 * i), 0, 0, 1);
      chk("fill_count", 64'(o_count), 64'd4);
      chk("fill_hold", 64'(o_hold), 64'd1);
      step(1, BASE + 64'h10, 0, 0, 1);
      chk("drop_count", 64'(o_count), 64'd4);
      for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 1);
      chk("drain_valid", 64'(o_valid), 64'd0);

      // Simultaneous push and pop at count 2, across pointer wrap.
      for (int i = 0; i < 2; i++) step(1, BASE + 64'h40 + 64'(4 * i), 0, 0, 1);
      for (int i = 2; i < 12; i++) step(1, BASE + 64'h40 + 64'(4 * i), 1, 0, 1);
      chk("pp_count", 64'(o_count), 64'd2);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 1);

      // Flush with a same-cycle push and pop.
      for (int i = 0; i < 3; i++) step(1, BASE + 64'h80 + 64'(4 * i), 0, 0, 1);
      step(1, BASE + 64'h100, 1, 1, 1);
      chk("flush_valid", 64'(o_valid), 64'd0);
      chk("flush_count", 64'(o_count), 64'd0);
      step(1, BASE + 64'h200, 0, 0, 1);
      chk("flush_head", o_pc, BASE + 64'h200);
      step(0, '0, 1, 0, 1);

      // Reset mid-operation.
      for (int i = 0; i < 4; i++) step(1, BASE + 64'hC0 + 64'(4 * i), 0, 0, 1);
      step(1, BASE + 64'hF0, 1, 0, 0);
      chk("mid_rst_valid", 64'(o_valid), 64'd0);
      chk("mid_rst_hold", 64'(o_hold), 64'd0);
      chk("mid_rst_count", 64'(o_count), 64'd0);
      step(1, BASE + 64'h300, 0, 0, 1);
      chk("mid_rst_head", o_pc, BASE + 64'h300);
      step(0, '0, 1, 0, 1);

      // Random traffic.
      rpc = BASE + 64'h1000;
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 9) < 7), rpc, ($urandom_range(0, 9) < 5),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) != 0));
         rpc = rpc + 64'd4;
      end
      step(0, '0, 1, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
